// File: rtl/idiv_preproc_ctrl.sv
// ---------------------------------------------------------------------------------------------
// idiv_preproc_ctrl
//
// Front end of the integer divide path of the divsqrt unit.
//  - Accepts a divide/remainder request over a start/ready handshake.
//  - Sign/zero-extends *W operands, takes absolute values and left-normalises them using
//    leading-zero counts.
//  - Raises the special-case flags the postprocessor consumes (bzero, altb, as, neg_quot).
//  - Sequences the digit-recurrence datapath (iter_en/last_iter) and reports done.
//
// Ports
//  clk, reset          clock, asynchronous active-low reset
//  start / ready       operand handshake; ready is high only while idle
//  a, b                dividend, divisor (XLEN bits)
//  signed_op, rem_op   signed operation; remainder (1) or quotient (0)
//  w64                 RV64 *W operation: only the low 32 bits of a/b are meaningful
//  wzero               early-termination request from the datapath (exact remainder reached)
//  flush               kill the current operation
//  stall               downstream stall, holds the done state
//  xnorm, dnorm        |A| << m_a, |B| << m_b
//  m_a, m_b            leading-zero counts of |A|, |B| (XLEN when the operand is zero)
//  n_iter              iteration count, 0 for the special cases
//  as, neg_quot, bzero, altb, rem_q, w64_q   registered operation flags
//  iter_en, last_iter  datapath step enable and final-step marker
//  done                result ready for postprocessing
// ---------------------------------------------------------------------------------------------
module idiv_preproc_ctrl #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned LOGR = 1,
  parameter int unsigned CNTW = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            signed_op,
  input  logic            rem_op,
  input  logic            w64,
  input  logic            wzero,
  input  logic            flush,
  input  logic            stall,
  output logic [XLEN-1:0] xnorm,
  output logic [XLEN-1:0] dnorm,
  output logic [CNTW-1:0] m_a,
  output logic [CNTW-1:0] m_b,
  output logic [CNTW-1:0] n_iter,
  output logic            as,
  output logic            neg_quot,
  output logic            bzero,
  output logic            altb,
  output logic            rem_q,
  output logic            w64_q,
  output logic            iter_en,
  output logic            last_iter,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StDone} state_e;

  // For *W operations the upper bits are replaced by the sign (signed) or zero (unsigned)
  // extension of bit 31. With XLEN=32 the loop is empty and the operand passes unchanged.
  function automatic logic [XLEN-1:0] op_ext(input logic [XLEN-1:0] x, input logic sgn,
                                             input logic w);
    logic [XLEN-1:0] r;
    r = x;
    if (w) begin
      for (int i = 32; i < XLEN; i++) begin
        r[i] = sgn & x[31];
      end
    end
    return r;
  endfunction

  // Leading-zero count; the highest set bit is the last one to update the result.
  function automatic logic [CNTW-1:0] lzc(input logic [XLEN-1:0] x);
    logic [CNTW-1:0] n;
    n = CNTW'(XLEN);
    for (int i = 0; i < XLEN; i++) begin
      if (x[i]) begin
        n = CNTW'(XLEN - 1 - i);
      end
    end
    return n;
  endfunction

  // ------------------------------------------------------------------------------------------
  // State
  // ------------------------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic [XLEN-1:0] a_abs_q, b_abs_q;
  logic [XLEN-1:0] xnorm_q, dnorm_q;
  logic [CNTW-1:0] m_a_q, m_b_q, n_iter_q;
  logic            as_q, neg_quot_q, bzero_q, altb_q, rem_op_q, w64_op_q;

  logic            latch_op;
  logic            load_prep;

  // ------------------------------------------------------------------------------------------
  // Operand preparation at accept time
  // ------------------------------------------------------------------------------------------
  logic [XLEN-1:0] a_ext, b_ext;
  logic [XLEN-1:0] a_abs_c, b_abs_c;
  logic            a_neg_c, b_neg_c;

  always_comb begin
    a_ext   = op_ext(a, signed_op, w64);
    b_ext   = op_ext(b, signed_op, w64);
    a_neg_c = signed_op & a_ext[XLEN-1];
    b_neg_c = signed_op & b_ext[XLEN-1];
    // Negating the most-negative value wraps to 2^(XLEN-1), which is the correct unsigned
    // magnitude, so no overflow handling is needed.
    a_abs_c = a_neg_c ? -a_ext : a_ext;
    b_abs_c = b_neg_c ? -b_ext : b_ext;
  end

  // ------------------------------------------------------------------------------------------
  // Normalisation and iteration count, evaluated during PREP from the latched magnitudes
  // ------------------------------------------------------------------------------------------
  logic [CNTW-1:0] m_a_c, m_b_c, diff_c, n_iter_c;
  logic            bzero_c, altb_c, special_c;

  always_comb begin
    m_a_c     = lzc(a_abs_q);
    m_b_c     = lzc(b_abs_q);
    bzero_c   = (b_abs_q == '0);
    altb_c    = (m_a_c > m_b_c);
    special_c = bzero_c | altb_c;
    // Number of quotient bits to develop; at least 1 whenever altb is clear.
    diff_c    = m_b_c - m_a_c + CNTW'(1);
    if (LOGR == 2) begin
      n_iter_c = (diff_c + CNTW'(1)) >> 1;
    end else begin
      n_iter_c = diff_c;
    end
  end

  // ------------------------------------------------------------------------------------------
  // Control FSM: next state
  // ------------------------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    latch_op  = 1'b0;
    load_prep = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          latch_op = 1'b1;
          state_d  = StPrep;
        end
      end
      StPrep: begin
        load_prep = 1'b1;
        if (special_c) begin
          state_d = StDone;
        end else begin
          state_d = StIter;
          cnt_d   = n_iter_c;
        end
      end
      StIter: begin
        cnt_d = cnt_q - CNTW'(1);
        // wzero ends the recurrence early; this cycle's step still happens.
        if (wzero || (cnt_q == CNTW'(1))) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (!stall) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides everything; previously captured flags are left untouched.
    if (flush) begin
      state_d   = StIdle;
      latch_op  = 1'b0;
      load_prep = 1'b0;
    end
  end

  // ------------------------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      a_abs_q    <= '0;
      b_abs_q    <= '0;
      xnorm_q    <= '0;
      dnorm_q    <= '0;
      m_a_q      <= '0;
      m_b_q      <= '0;
      n_iter_q   <= '0;
      as_q       <= 1'b0;
      neg_quot_q <= 1'b0;
      bzero_q    <= 1'b0;
      altb_q     <= 1'b0;
      rem_op_q   <= 1'b0;
      w64_op_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_op) begin
        a_abs_q    <= a_abs_c;
        b_abs_q    <= b_abs_c;
        as_q       <= a_neg_c;
        neg_quot_q <= a_neg_c ^ b_neg_c;
        rem_op_q   <= rem_op;
        w64_op_q   <= w64;
      end
      if (load_prep) begin
        m_a_q    <= m_a_c;
        m_b_q    <= m_b_c;
        xnorm_q  <= a_abs_q << m_a_c;
        dnorm_q  <= b_abs_q << m_b_c;
        bzero_q  <= bzero_c;
        altb_q   <= altb_c;
        n_iter_q <= special_c ? '0 : n_iter_c;
      end
    end
  end

  // ------------------------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------------------------
  assign ready     = (state_q == StIdle);
  assign iter_en   = (state_q == StIter);
  assign last_iter = (state_q == StIter) && (cnt_q == CNTW'(1));
  assign done      = (state_q == StDone);

  assign xnorm    = xnorm_q;
  assign dnorm    = dnorm_q;
  assign m_a      = m_a_q;
  assign m_b      = m_b_q;
  assign n_iter   = n_iter_q;
  assign as       = as_q;
  assign neg_quot = neg_quot_q;
  assign bzero    = bzero_q;
  assign altb     = altb_q;
  assign rem_q    = rem_op_q;
  assign w64_q    = w64_op_q;

endmodule

// File: tb/tb_idiv_preproc_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_idiv_preproc_ctrl
//
// Directed bench for idiv_preproc_ctrl. Two instances share all inputs: dut (XLEN=64, LOGR=1)
// and dut2 (XLEN=64, LOGR=2). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------------------------
module tb_idiv_preproc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, signed_op, rem_op, w64, wzero, flush, stall;
  logic [63:0] a, b;

  logic        ready, as, neg_quot, bzero, altb, rem_q, w64_q, iter_en, last_iter, done;
  logic [63:0] xnorm, dnorm;
  logic [6:0]  m_a, m_b, n_iter;

  logic        ready2, as2, neg_quot2, bzero2, altb2, rem_q22, w64_q2, iter_en2, last_iter2, done2;
  logic [63:0] xnorm2, dnorm2;
  logic [6:0]  m_a2, m_b2, n_iter2;

  int n_cmp = 0;
  int n_bad = 0;

  idiv_preproc_ctrl #(.XLEN(64), .LOGR(1)) dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .a(a), .b(b),
    .signed_op(signed_op), .rem_op(rem_op), .w64(w64), .wzero(wzero), .flush(flush),
    .stall(stall), .xnorm(xnorm), .dnorm(dnorm), .m_a(m_a), .m_b(m_b), .n_iter(n_iter),
    .as(as), .neg_quot(neg_quot), .bzero(bzero), .altb(altb), .rem_q(rem_q), .w64_q(w64_q),
    .iter_en(iter_en), .last_iter(last_iter), .done(done)
  );

  idiv_preproc_ctrl #(.XLEN(64), .LOGR(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .ready(ready2), .a(a), .b(b),
    .signed_op(signed_op), .rem_op(rem_op), .w64(w64), .wzero(wzero), .flush(flush),
    .stall(stall), .xnorm(xnorm2), .dnorm(dnorm2), .m_a(m_a2), .m_b(m_b2), .n_iter(n_iter2),
    .as(as2), .neg_quot(neg_quot2), .bzero(bzero2), .altb(altb2), .rem_q(rem_q22),
    .w64_q(w64_q2), .iter_en(iter_en2), .last_iter(last_iter2), .done(done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation and run until done. lat counts cycles from the accept cycle (0).
  // hold keeps start high through PREP with different operands, which must be ignored.
  task automatic do_op(input logic [63:0] ta, input logic [63:0] tbv, input logic s,
                       input logic r, input logic w, input bit use2, input bit hold,
                       output int lat, output int iters, output int last_cyc);
    a = ta; b = tbv; signed_op = s; rem_op = r; w64 = w; start = 1'b1;
    check("ready_at_start", use2 ? ready2 : ready, 1);
    step();
    lat = 1; iters = 0; last_cyc = -1;
    if (hold) begin
      a = 64'd3; b = 64'd100;
    end else begin
      start = 1'b0;
    end
    while (!(use2 ? done2 : done) && lat < 200) begin
      if (use2 ? iter_en2 : iter_en) iters++;
      if (use2 ? last_iter2 : last_iter) last_cyc = lat;
      step();
      lat++;
      start = 1'b0;
    end
    if (!(use2 ? done2 : done)) check("done_timeout", use2 ? done2 : done, 1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(ready && ready2) && k < 100) begin
      step();
      k++;
    end
    if (!(ready && ready2)) check("idle_timeout", ready & ready2, 1);
  endtask

  int lat, it, lc, nd, seen;

  initial begin
    reset = 1'b0; start = 1'b0; signed_op = 1'b0; rem_op = 1'b0; w64 = 1'b0;
    wzero = 1'b0; flush = 1'b0; stall = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_iter_en", iter_en, 0);
    check("rst_n_iter", n_iter, 0);
    check("rst_xnorm", xnorm, 0);
    check("rst_m_a", m_a, 0);
    check("rst_as", as, 0);
    reset = 1'b1;
    step();

    // 100 / 7 unsigned
    do_op(64'd100, 64'd7, 0, 0, 0, 0, 0, lat, it, lc);
    check("t1_lat", lat, 7);
    check("t1_iters", it, 5);
    check("t1_last_iter_cyc", lc, 6);
    check("t1_m_a", m_a, 57);
    check("t1_m_b", m_b, 61);
    check("t1_n_iter", n_iter, 5);
    check("t1_xnorm", xnorm, 64'hC800_0000_0000_0000);
    check("t1_dnorm", dnorm, 64'hE000_0000_0000_0000);
    check("t1_bzero", bzero, 0);
    check("t1_altb", altb, 0);
    check("t1_as", as, 0);
    check("t1_neg_quot", neg_quot, 0);
    check("t1_rem_q", rem_q, 0);
    step();
    check("t1_ready_after", ready, 1);
    check("t1_done_after", done, 0);

    // Back-to-back: -100 rem 7 signed, with a stray start held through PREP
    do_op(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1, 1, 0, 0, 1, lat, it, lc);
    check("t2_lat", lat, 7);
    check("t2_iters", it, 5);
    check("t2_as", as, 1);
    check("t2_neg_quot", neg_quot, 1);
    check("t2_xnorm", xnorm, 64'hC800_0000_0000_0000);
    check("t2_rem_q", rem_q, 1);
    check("t2_n_iter", n_iter, 5);
    check("t2_altb", altb, 0);
    step();

    // Divide by zero
    do_op(64'd100, 64'd0, 0, 0, 0, 0, 0, lat, it, lc);
    check("t3_lat", lat, 2);
    check("t3_iters", it, 0);
    check("t3_bzero", bzero, 1);
    check("t3_n_iter", n_iter, 0);
    check("t3_m_b", m_b, 64);
    step();

    // A < B
    do_op(64'd3, 64'd100, 0, 0, 0, 0, 0, lat, it, lc);
    check("t4_lat", lat, 2);
    check("t4_iters", it, 0);
    check("t4_altb", altb, 1);
    check("t4_bzero", bzero, 0);
    check("t4_n_iter", n_iter, 0);
    check("t4_m_a", m_a, 62);
    check("t4_m_b", m_b, 57);
    step();

    // Most-negative / -1 signed
    do_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, lat, it, lc);
    check("t5_lat", lat, 66);
    check("t5_iters", it, 64);
    check("t5_m_a", m_a, 0);
    check("t5_m_b", m_b, 63);
    check("t5_n_iter", n_iter, 64);
    check("t5_as", as, 1);
    check("t5_neg_quot", neg_quot, 0);
    check("t5_xnorm", xnorm, 64'h8000_0000_0000_0000);
    check("t5_dnorm", dnorm, 64'h8000_0000_0000_0000);
    step();

    // LOGR=2 instance, *W signed op: low word 0x40
    wait_idle();
    do_op(64'hFFFF_FFFF_0000_0040, 64'd3, 1, 0, 1, 1, 0, lat, it, lc);
    check("t6_lat2", lat, 5);
    check("t6_iters2", it, 3);
    check("t6_m_a2", m_a2, 57);
    check("t6_m_b2", m_b2, 62);
    check("t6_n_iter2", n_iter2, 3);
    check("t6_w64_q2", w64_q2, 1);
    check("t6_as2", as2, 0);
    check("t6_neg_quot2", neg_quot2, 0);
    check("t6_bzero2", bzero2, 0);
    check("t6_altb2", altb2, 0);
    check("t6_rem_q2", rem_q22, 0);
    check("t6_xnorm2", xnorm2, 64'h8000_0000_0000_0000);
    check("t6_dnorm2", dnorm2, 64'hC000_0000_0000_0000);
    step();
    wait_idle();
    check("t6_n_iter1", n_iter, 6);
    check("t6_w64_q1", w64_q, 1);

    // Early termination via wzero in the 2nd ITER cycle, then a 3-cycle stall in DONE
    a = 64'd100; b = 64'd7; signed_op = 1'b0; rem_op = 1'b0; w64 = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t7_iter1", iter_en, 1);
    step();
    check("t7_iter2", iter_en, 1);
    wzero = 1'b1;
    step();
    wzero = 1'b0;
    check("t7_done_after_wzero", done, 1);
    stall = 1'b1;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) nd++;
      if (i == 3) begin
        check("t7_xnorm_held", xnorm, 64'hC800_0000_0000_0000);
        stall = 1'b0;
      end
      step();
    end
    check("t7_done_cycles", nd, 4);
    check("t7_ready", ready, 1);

    // Flush in the middle of ITER
    a = 64'd100; b = 64'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t8_ready", ready, 1);
    check("t8_iter_en", iter_en, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) seen++;
      step();
    end
    check("t8_no_done", seen, 0);

    // Flush wins over start in IDLE
    start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("t8b_ready", ready, 1);
    step();
    check("t8b_ready2", ready, 1);
    check("t8b_iter_en", iter_en, 0);

    // Asynchronous reset in the middle of ITER
    a = 64'hFFFF_FFFF_FFFF_FF9C; b = 64'd7; signed_op = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t9_iter_before", iter_en, 1);
    check("t9_as_before", as, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t9_ready", ready, 1);
    check("t9_iter_en", iter_en, 0);
    check("t9_as", as, 0);
    check("t9_n_iter", n_iter, 0);
    check("t9_xnorm", xnorm, 0);
    check("t9_m_b", m_b, 0);
    check("t9_done", done, 0);
    reset = 1'b1;
    step();
    signed_op = 1'b0;
    do_op(64'd100, 64'd7, 0, 0, 0, 0, 0, lat, it, lc);
    check("t10_lat", lat, 7);
    check("t10_iters", it, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
